mem_arbiter: RTL
================

# mem_arbiter

- Shares one single-port, fixed-latency unified memory between two requesters:
  - the instruction-fetch port (I);
  - the data load/store port (D).
- Each access is serialized through a small state machine, and each requester gets a one-cycle ready pulse on completion.
- Sits between the CPU datapath and the memory array; the CPU stalls its fetch/memory stage until the matching ready pulse.

## Interface
Parameters:
- LATENCY, default 2: memory read latency in cycles, counted from the mem_en cycle; legal range 1..15.
- AW, default 32: address width.
- DW, default 32: data width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  instruction read request; held high until if_ready.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_rdata  out  DW  fetched word; registered, held until the next I completion.
- if_ready  out  1  one-cycle completion pulse for I.
- dm_req  in  1  data request; held high until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load result; registered, held until the next D load completion.
- dm_ready  out  1  one-cycle completion pulse for D.
- mem_en  out  1  one-cycle access strobe to memory.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  AW  registered access address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  read data, valid exactly LATENCY cycles after the mem_en cycle.

## Operation
States:
- IDLE:
  - Samples if_req and dm_req.
  - With any request pending, latches grant owner, address, we and wdata, then moves to ACCESS.
  - With no request, stays in IDLE.
- ACCESS:
  - mem_en = 1 in the first cycle only.
  - A down-counter loads LATENCY and decrements each cycle.
  - At count 0, captures mem_rdata into the owner's rdata register (loads only), then moves to RESP.
  - Stores skip the capture; dm_rdata is unchanged.
- RESP:
  - Asserts the owner's ready for one cycle.
  - Accepts no request this cycle.
  - Returns to IDLE.
  - If the owner dropped req during the access, the memory access still completes (a store still commits), but ready is suppressed.

Arbitration and reset:
- Simultaneous requests: the default policy is fixed D-priority; I may starve while dm_req stays high.
- Reset: all outputs return to 0 (rdata registers = 0), state = IDLE, counter = 0.
- Reset mid-access discards the in-flight transaction, and no ready is issued.
- If reset and a request coincide, reset wins.

## Timing
- Request sampled in IDLE at cycle 0:
  - mem_en in cycle 1;
  - mem_rdata valid in cycle 1+LATENCY;
  - ready in cycle 2+LATENCY;
  - IDLE in cycle 3+LATENCY.
- Back-to-back throughput: one access per LATENCY+3 cycles.
- mem_addr, mem_we and mem_wdata are stable from the mem_en cycle through RESP.
- if_ready and dm_ready are never high in the same cycle.

## Configuration
- ARB_RR_EN defined:
  - Round-robin arbitration with a 1-bit last-grant pointer, updated at each grant.
  - On a tie, the requester not granted last wins.
  - The pointer resets to "I last", so D wins the first tie.
- ARB_RR_EN undefined:
  - Fixed D-priority; no pointer register is instantiated.

## Test plan
- Reset:
  - Stimulus: reset high for 3 cycles with if_req = dm_req = 1.
  - Required: mem_en, if_ready, dm_ready, if_rdata and dm_rdata all 0 throughout.
- Single fetch (LATENCY = 2):
  - Stimulus: if_req at cycle 0, if_addr = 0x4; memory returns 0x20100009 in cycle 3.
  - Required: mem_en with mem_addr = 0x4 in cycle 1; if_ready in cycle 4 with if_rdata = 0x20100009.
- Store:
  - Stimulus: dm_req = dm_we = 1, dm_addr = 0x10, dm_wdata = 0xDEADBEEF at cycle 0.
  - Required: mem_en = mem_we = 1 with those values in cycle 1; dm_ready in cycle 4; dm_rdata unchanged.
- Tie, fixed priority (ARB_RR_EN undefined, LATENCY = 2):
  - Stimulus: I and D loads requested in cycle 0.
  - Required: D mem_en in cycle 1, dm_ready in cycle 4; I mem_en in cycle 6, if_ready in cycle 9.
- Sustained contention:
  - Stimulus: both reqs held for 4 accesses.
  - Required with ARB_RR_EN: grant order D, I, D, I.
  - Required without ARB_RR_EN: D, D, D, D, with no if_ready.
- Reset mid-access:
  - Stimulus: reset pulsed in cycle 2 of a D load.
  - Required: no dm_ready; state IDLE and all outputs 0 in cycle 3; the next request proceeds normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes I-fetch and D load/store accesses onto one fixed-latency memory port.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise D has fixed priority.
module mem_arbiter #(
   parameter int LATENCY = 2,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [3:0] LAT = 4'(LATENCY);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          dm_own_q, dm_own_d;
   logic          keep_q, keep_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] dm_rdata_q, dm_rdata_d;
   logic          pick_dm;

`ifdef ARB_RR_EN
   logic last_dm_q, last_dm_d;
   // On a tie, whoever was not granted last wins; reset value means "I last".
   assign pick_dm = dm_req & (~if_req | ~last_dm_q);
   always_comb last_dm_d = (state_q == IDLE && (if_req || dm_req)) ? pick_dm : last_dm_q;
   always_ff @(posedge clock) last_dm_q <= reset ? 1'b0 : last_dm_d;
`else
   assign pick_dm = dm_req;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dm_own_q   <= 1'b0;
         keep_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dm_own_q   <= dm_own_d;
         keep_q     <= keep_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dm_own_d   = dm_own_q;
      keep_d     = keep_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      case (state_q)
         IDLE: if (if_req || dm_req) begin
            state_d  = ACCESS;
            cnt_d    = LAT;
            dm_own_d = pick_dm;
            keep_d   = 1'b1;
            we_d     = pick_dm & dm_we;
            addr_d   = pick_dm ? dm_addr : if_addr;
            wdata_d  = pick_dm ? dm_wdata : '0;
         end
         ACCESS: begin
            // A requester that lets go mid-access forfeits its ready pulse.
            keep_d = keep_q & (dm_own_q ? dm_req : if_req);
            cnt_d  = (cnt_q == '0) ? cnt_q : cnt_q - 4'd1;
            if (cnt_q == '0) begin
               state_d    = RESP;
               if_rdata_d = (!we_q && !dm_own_q) ? mem_rdata : if_rdata_q;
               dm_rdata_d = (!we_q && dm_own_q) ? mem_rdata : dm_rdata_q;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_en    = (state_q == ACCESS) && (cnt_q == LAT);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_ready  = (state_q == RESP) && keep_q && !dm_own_q;
   assign dm_ready  = (state_q == RESP) && keep_q && dm_own_q;
endmodule
